// File: rtl/toggle_rx_fifo.sv
// Receive stage for the toggle-handshake byte link: captures toggled requests into a FIFO and
// re-presents them as a valid/ready stream. Define TOGGLE_RX_SYNC_EN to synchronize get_it.
module toggle_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         shared,
    input  logic                     get_it,
    output logic                     put_it,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("toggle_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    logic                 req_lvl;
    logic                 seen_q, seen_d;
    logic                 put_q, put_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic                 pending;
    logic                 full;
    logic                 capture;
    logic                 pop;

`ifdef TOGGLE_RX_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = get_it;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign req_lvl = sync2_q;
`else
    assign req_lvl = get_it;
`endif

    // Full is judged on the pre-edge count, so a same-edge pop cannot admit a capture.
    always_comb begin
        pending = (req_lvl != seen_q);
        full    = (count_q == FullCount);
        capture = pending && !full;
        pop     = (count_q != '0) && dout_ready;
    end

    always_comb begin
        seen_d   = seen_q;
        put_d    = put_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (capture) begin
            mem_d[wr_ptr_q] = shared;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            seen_d          = req_lvl;
            put_d           = ~put_q;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({capture, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q   <= 1'b0;
            put_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            seen_q   <= seen_d;
            put_q    <= put_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        put_it     = put_q;
        dout       = mem_q[rd_ptr_q];
        dout_valid = (count_q != '0);
        count      = count_q;
    end

endmodule

// File: tb/tb_toggle_rx_fifo.sv
// Scoreboard bench for toggle_rx_fifo: sent bytes are queued, a negedge monitor checks each pop.
`timescale 1ns/1ps
module tb_toggle_rx_fifo;

`ifdef TOGGLE_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] shared;
    logic       get_it;
    logic       put_it;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic [2:0] count;

    int         n_pass;
    int         n_total;
    logic [7:0] exp_q[$];

    toggle_rx_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .shared     (shared),
        .get_it     (get_it),
        .put_it     (put_it),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        shared = b;
        get_it = ~get_it;
        exp_q.push_back(b);
    endtask

    task automatic send_wait(input logic [7:0] b);
        int n;
        send(b);
        n = 0;
        while (put_it !== get_it && n < 20) begin
            tick();
            n++;
        end
        chk("ack_latency", n, LAT);
    endtask

    // Monitor: inputs only change just after posedge, so valid&ready here means a pop next edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pop: got %0h, expected no data", dout);
            end else begin
                chk("pop_data", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        n_pass     = 0;
        n_total    = 0;
        reset_n    = 1'b1;
        get_it     = 1'b0;
        shared     = 8'h00;
        dout_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_put_it", put_it, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_count", count, 0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Ready while empty must not move anything.
        dout_ready = 1'b1;
        repeat (5) tick();
        dout_ready = 1'b0;
        chk("empty_ready_count", count, 0);
        chk("empty_ready_valid", dout_valid, 0);
        chk("empty_ready_dout", dout, 0);

        // Single transfer.
        send_wait(8'h01);
        chk("single_count", count, 1);
        chk("single_valid", dout_valid, 1);
        chk("single_dout", dout, 8'h01);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("single_pop_count", count, 0);
        chk("single_pop_valid", dout_valid, 0);

        // Three back-to-back, then drain.
        send_wait(8'h01);
        send_wait(8'h02);
        send_wait(8'h03);
        chk("three_count", count, 3);
        dout_ready = 1'b1;
        repeat (2) tick();
        chk("three_valid_mid", dout_valid, 1);
        tick();
        dout_ready = 1'b0;
        chk("three_valid_end", dout_valid, 0);

        // Fill to DEPTH, fifth request is held off until a pop frees a slot.
        send_wait(8'd10);
        send_wait(8'd11);
        send_wait(8'd12);
        send_wait(8'd13);
        chk("fill_count", count, 4);
        send(8'd14);
        repeat (5) tick();
        chk("full_no_ack", put_it != get_it, 1);
        chk("full_count", count, 4);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("full_pop_no_ack", put_it != get_it, 1);
        chk("full_pop_count", count, 3);
        tick();
        chk("full_late_ack", put_it, get_it);
        chk("full_late_count", count, 4);
        dout_ready = 1'b1;
        repeat (4) tick();
        dout_ready = 1'b0;
        chk("fill_drain_valid", dout_valid, 0);

        // Capture and pop on the same edge.
        send_wait(8'd20);
        send_wait(8'd21);
        chk("simul_pre_count", count, 2);
        send(8'd22);
        repeat (LAT - 1) tick();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("simul_count", count, 2);
        chk("simul_ack", put_it, get_it);

        // Stream ten bytes with continuous popping to exercise pointer wrap.
        dout_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_wait(8'(8'd30 + i));
        repeat (4) tick();
        dout_ready = 1'b0;
        chk("wrap_valid", dout_valid, 0);
        chk("wrap_queue_empty", exp_q.size(), 0);

        // Asynchronous reset with data buffered and a request pending.
        send_wait(8'd40);
        send_wait(8'd41);
        send_wait(8'd42);
        chk("prerst_count", count, 3);
        send(8'd43);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_put_it", put_it, 0);
        chk("arst_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
        exp_q.delete();
        get_it = 1'b0;
        shared = 8'h00;
        repeat (2) tick();
        @(negedge clk) reset_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_count", count, 0);
        chk("post_rst_put_it", put_it, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
